// File: rtl/fetch_entry_fifo.sv
// Elastic in-order buffer between the frontend fetch-entry output and id_stage.
// Optional same-cycle bypass when empty: define FETCH_FIFO_BYPASS_EN.

package ariane_pkg;
    typedef struct packed {
        logic [63:0] address;
        logic [31:0] instruction;
        logic        ex_valid;
    } fetch_entry_t;
endpackage

module fetch_entry_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  ariane_pkg::fetch_entry_t     fetch_entry_i,
    input  logic                         fetch_entry_valid_i,
    output logic                         fetch_entry_ready_o,
    output ariane_pkg::fetch_entry_t     fetch_entry_o,
    output logic                         fetch_entry_valid_o,
    input  logic                         fetch_entry_ready_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    ariane_pkg::fetch_entry_t mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;

    logic full_s;
    logic empty_s;
    logic push_s;
    logic pop_s;
    logic through_s;
    logic wr_en_s;
    logic rd_en_s;
    logic valid_s;
    ariane_pkg::fetch_entry_t entry_s;

    assign full_s  = (count_r == CNT_FULL);
    assign empty_s = (count_r == {CNT_W{1'b0}});

    // Head presentation; with bypass an empty buffer forwards the incoming entry.
    always_comb begin
        valid_s = 1'b0;
        entry_s = mem_r[rd_ptr_r];
`ifdef FETCH_FIFO_BYPASS_EN
        if (empty_s) begin
            valid_s = fetch_entry_valid_i && !flush_i;
            entry_s = fetch_entry_i;
        end else begin
            valid_s = !flush_i;
            entry_s = mem_r[rd_ptr_r];
        end
`else
        if (empty_s) begin
            valid_s = 1'b0;
        end else begin
            valid_s = !flush_i;
        end
`endif
    end

    assign push_s = fetch_entry_valid_i && !full_s && !flush_i;
    assign pop_s  = valid_s && fetch_entry_ready_i && !flush_i;

`ifdef FETCH_FIFO_BYPASS_EN
    // An entry consumed in the cycle it arrives at an empty buffer is never stored.
    assign through_s = empty_s && push_s && pop_s;
`else
    assign through_s = 1'b0;
`endif

    assign wr_en_s = push_s && !through_s;
    assign rd_en_s = pop_s && !through_s;

    assign fetch_entry_ready_o = !full_s;
    assign fetch_entry_valid_o = valid_s;
    assign fetch_entry_o       = entry_s;
    assign count_o             = count_r;

    // Pointer and occupancy tracking; flush empties the buffer without touching storage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (flush_i) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            if (wr_en_s && !rd_en_s) begin
                count_r <= count_r + CNT_ONE;
            end else if (rd_en_s && !wr_en_s) begin
                count_r <= count_r - CNT_ONE;
            end else begin
                count_r <= count_r;
            end
        end
    end

    // Entry storage, cleared only by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_r[i] <= '0;
            end
        end else if (wr_en_s) begin
            mem_r[wr_ptr_r] <= fetch_entry_i;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

endmodule

// File: tb/tb_fetch_entry_fifo.sv
// Scoreboard bench for fetch_entry_fifo: a queue-based model of accepted entries,
// a per-cycle driver and an independent output monitor.
module tb_fetch_entry_fifo;
    import ariane_pkg::*;

    localparam int DEPTH = 4;
`ifdef FETCH_FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         flush_i;
    fetch_entry_t fetch_entry_i;
    logic         fetch_entry_valid_i;
    logic         fetch_entry_ready_o;
    fetch_entry_t fetch_entry_o;
    logic         fetch_entry_valid_o;
    logic         fetch_entry_ready_i;
    logic [$clog2(DEPTH+1)-1:0] count_o;

    fetch_entry_fifo #(.DEPTH(DEPTH)) dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .flush_i             (flush_i),
        .fetch_entry_i       (fetch_entry_i),
        .fetch_entry_valid_i (fetch_entry_valid_i),
        .fetch_entry_ready_o (fetch_entry_ready_o),
        .fetch_entry_o       (fetch_entry_o),
        .fetch_entry_valid_o (fetch_entry_valid_o),
        .fetch_entry_ready_i (fetch_entry_ready_i),
        .count_o             (count_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;
    fetch_entry_t exp_q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic fetch_entry_t mk(input logic [31:0] addr);
        fetch_entry_t e;
        e.address     = {32'h0, addr};
        e.instruction = $urandom;
        e.ex_valid    = 1'($urandom_range(0, 1));
        return e;
    endfunction

    // One clock cycle of stimulus; the model is the queue of entries accepted but not yet consumed.
    task automatic cycle(input bit v, input logic [31:0] addr, input bit rdy, input bit fl);
        int cnt;
        bit acc;
        bit ev;
        @(posedge clk_i);
        #1;
        fetch_entry_i       = mk(addr);
        fetch_entry_valid_i = v;
        fetch_entry_ready_i = rdy;
        flush_i             = fl;
        cnt = exp_q.size();
        acc = v && (cnt < DEPTH) && !fl;
        ev  = !fl && ((cnt > 0) || (BYP && v));
        if (fl) exp_q.delete();
        else if (acc) exp_q.push_back(fetch_entry_i);
        @(negedge clk_i);
        check("count_o", 128'(count_o), 128'(cnt));
        check("ready_o", 128'(fetch_entry_ready_o), 128'(cnt < DEPTH));
        check("valid_o", 128'(fetch_entry_valid_o), 128'(ev));
    endtask

    // Monitor: every handshake on the output side must deliver the oldest expected entry.
    always @(negedge clk_i) begin
        fetch_entry_t e;
        if (rst_ni === 1'b1 && fetch_entry_valid_o === 1'b1 && fetch_entry_ready_i === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got addr %0h expected no entry at %0t",
                         fetch_entry_o.address, $time);
            end else begin
                e = exp_q.pop_front();
                check("out_entry", 128'(fetch_entry_o), 128'(e));
            end
        end
    end

    initial begin
        rst_ni              = 1'b0;
        flush_i             = 1'b0;
        fetch_entry_i       = '0;
        fetch_entry_valid_i = 1'b0;
        fetch_entry_ready_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #2;
        check("rst_count", 128'(count_o), 128'(0));
        check("rst_valid", 128'(fetch_entry_valid_o), 128'(0));
        check("rst_ready", 128'(fetch_entry_ready_o), 128'(1));
        check("rst_entry", 128'(fetch_entry_o), 128'(0));
        @(negedge clk_i);
        rst_ni = 1'b1;

        repeat (2) cycle(1'b0, 32'h0, 1'b0, 1'b0);

        // Fill to full with decode stalled, offer a fifth, then drain in order.
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'h80000000 + 32'(4 * i), 1'b0, 1'b0);
        cycle(1'b1, 32'h80000010, 1'b0, 1'b0);
        cycle(1'b1, 32'h80000014, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Sustained push/pop at two entries of occupancy, wrapping the pointers.
        cycle(1'b1, 32'h80000100, 1'b0, 1'b0);
        cycle(1'b1, 32'h80000104, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b1, 32'h80000108 + 32'(4 * i), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Flush at three entries with an entry offered in the same cycle.
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h80000200 + 32'(4 * i), 1'b0, 1'b0);
        cycle(1'b1, 32'hDEAD0000, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Empty buffer, entry offered with decode ready.
        cycle(1'b1, 32'h80001000, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset between clock edges with two entries stored.
        cycle(1'b1, 32'h80002000, 1'b0, 1'b0);
        cycle(1'b1, 32'h80002004, 1'b0, 1'b0);
        @(posedge clk_i);
        #1;
        fetch_entry_i       = '0;
        fetch_entry_valid_i = 1'b0;
        fetch_entry_ready_i = 1'b0;
        #1;
        check("pre_rst_count", 128'(count_o), 128'(2));
        rst_ni = 1'b0;
        #1;
        check("async_rst_count", 128'(count_o), 128'(0));
        check("async_rst_valid", 128'(fetch_entry_valid_o), 128'(0));
        check("async_rst_ready", 128'(fetch_entry_ready_o), 128'(1));
        check("async_rst_entry", 128'(fetch_entry_o), 128'(0));
        exp_q.delete();
        #1;
        rst_ni = 1'b1;

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 32'h90000000 + 32'(4 * i),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
        end
        for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
        check("drained", 128'(exp_q.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_entry_fifo.md
# fetch_entry_fifo

- Elastic buffer between the frontend instruction output and `id_stage`.
- Absorbs fetch entries when decode/issue back-pressures and presents them in order through the same valid/ready fetch-entry handshake that `id_stage` consumes.
- Flushing on `flush_i` discards all buffered entries, so no stale instruction reaches decode after a redirect, exception or landing-pad (`xLPAD`) fault recovery.
- Optional same-cycle bypass removes the buffer's latency when it is empty.

## Interface
Parameters:
- `DEPTH`, default 4: number of entries; power of two, ≥2.

Ports:
- `clk_i`  in  1  clock; all state updates on rising edge.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `flush_i`  in  1  discard all stored entries and any entry offered this cycle.
- `fetch_entry_i`  in  `ariane_pkg::fetch_entry_t`  entry from frontend.
- `fetch_entry_valid_i`  in  1  `fetch_entry_i` valid.
- `fetch_entry_ready_o`  out  1  buffer accepts the entry this cycle.
- `fetch_entry_o`  out  `ariane_pkg::fetch_entry_t`  head entry to `id_stage`.
- `fetch_entry_valid_o`  out  1  `fetch_entry_o` valid.
- `fetch_entry_ready_i`  in  1  `id_stage` takes the head entry this cycle.
- `count_o`  out  `$clog2(DEPTH+1)`  entries currently stored.

## Operation
- Storage: circular array of `DEPTH` entries, read and write pointers of `$clog2(DEPTH)` bits, and a count register.
  - Pointers wrap modulo `DEPTH`.
  - Full: `count == DEPTH`. Empty: `count == 0`.
- Push: `fetch_entry_valid_i && fetch_entry_ready_o && !flush_i`. Writes the entry at the write pointer and increments the write pointer.
- Pop: `fetch_entry_valid_o && fetch_entry_ready_i && !flush_i`. Increments the read pointer.
- `fetch_entry_ready_o = !full`. It does not depend on `flush_i` or `fetch_entry_ready_i`.
  - When full, no push occurs, even if a pop happens in the same cycle.
- `fetch_entry_valid_o = !empty && !flush_i` (bypass case below).
- `fetch_entry_o` = entry at the read pointer.
- Simultaneous push and pop (not full, not empty): count unchanged; both pointers advance.
- Flush: takes priority over everything.
  - Offered entry dropped; no pop reported.
  - Next cycle: count=0, both pointers=0.
  - Array contents are not cleared.
- Ordering: strictly FIFO. Entries are never reordered, duplicated, or modified.
- Reset mid-operation: all state returns immediately to reset values, asynchronously.

## Timing
Reset values:
- `count_o`=0
- `fetch_entry_valid_o`=0
- `fetch_entry_ready_o`=1
- pointers=0
- array contents='0, so `fetch_entry_o`='0

Latency (without bypass): an entry pushed in cycle N is visible on `fetch_entry_o` with valid in cycle N+1 at the earliest.

Throughput: one push and one pop per cycle sustained.

Count update:
- +1 on push-only.
- −1 on pop-only.
- 0 on both or neither.
- Forced to 0 on flush.

`count_o` is registered; it never exceeds `DEPTH`.

## Configuration
- `FETCH_FIFO_BYPASS_EN` defined:
  - When empty, `fetch_entry_valid_o = fetch_entry_valid_i && !flush_i` and `fetch_entry_o = fetch_entry_i`.
  - If `fetch_entry_ready_i` is also high, the entry passes through in the same cycle and is not stored (count stays 0).
  - If `fetch_entry_ready_i` is low, it is stored normally.
- `FETCH_FIFO_BYPASS_EN` undefined:
  - Every entry is stored first; minimum latency is 1 cycle.
  - `fetch_entry_valid_o` is purely registered-state derived.

## Test plan
- Reset, then idle:
  - `count_o`=0, `fetch_entry_valid_o`=0, `fetch_entry_ready_o`=1.
- Push addresses 0x80000000, 0x80000004, 0x80000008, 0x8000000C with `fetch_entry_ready_i`=0 (DEPTH=4):
  - `count_o` reaches 4; `fetch_entry_ready_o`=0.
  - A fifth valid entry is not accepted.
  - Then raise `fetch_entry_ready_i`: the four addresses appear in order, one per cycle.
- Sustained push and pop with count=2 for 20 cycles:
  - `count_o` stays 2.
  - Output addresses match input order with a 2-entry lag; pointers wrap past DEPTH correctly.
- Count=3 plus a valid input, with `flush_i`=1:
  - In the flush cycle, `fetch_entry_valid_o`=0.
  - Next cycle: `count_o`=0, `fetch_entry_valid_o`=0.
  - The flushed input never appears on the output.
- Assert `rst_ni`=0 asynchronously mid-stream at count=2:
  - Outputs go immediately to reset values without waiting for a clock edge.
- Empty buffer, push 0x80001000 with `fetch_entry_ready_i`=1:
  - With `FETCH_FIFO_BYPASS_EN`: output is valid with 0x80001000 in the same cycle; count stays 0.
  - Without the macro: output is valid in the next cycle; count=1 for one cycle.
